// File: rtl/classifier_head.sv
// classifier_head: FC head over a pooled int8 vector; one MAC, rescale, sat8, argmax.
// Optional macro CLASSIFIER_HEAD_ROUND_EN: round half up before the shift.
module classifier_head #(
  parameter int VEC_LEN   = 16,
  parameter int NUM_CLASS = 5,
  parameter int ACC_W     = 24,
  parameter int SHIFT     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic signed [7:0]            vec_in     [VEC_LEN],
  input  logic signed [7:0]            weight_in  [NUM_CLASS][VEC_LEN],
  input  logic signed [15:0]           bias_in    [NUM_CLASS],
  output logic signed [7:0]            logits_out [NUM_CLASS],
  output logic [$clog2(NUM_CLASS)-1:0] class_idx,
  output logic                         busy,
  output logic                         done
);
  localparam int KW = $clog2(VEC_LEN);
  localparam int CW = $clog2(NUM_CLASS);
  localparam logic [KW-1:0] K_LAST = KW'(VEC_LEN - 1);
  localparam logic [CW-1:0] C_LAST = CW'(NUM_CLASS - 1);
  localparam logic signed [ACC_W-1:0] P127 = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] N128 = -ACC_W'(128);
`ifdef CLASSIFIER_HEAD_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1 << (SHIFT - 1));
`else
  localparam logic signed [ACC_W-1:0] RND = '0;
`endif

  typedef enum logic [1:0] {IDLE, MAC, STORE, DONE} state_t;

  state_t                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic [CW-1:0]            c_q, c_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [7:0]        v_q [VEC_LEN];
  logic signed [7:0]        v_d [VEC_LEN];
  logic signed [7:0]        lbuf_q [NUM_CLASS];
  logic signed [7:0]        lbuf_d [NUM_CLASS];
  logic signed [7:0]        logits_q [NUM_CLASS];
  logic signed [7:0]        logits_d [NUM_CLASS];
  logic signed [ACC_W-1:0]  best_r_q, best_r_d;
  logic [CW-1:0]            best_idx_q, best_idx_d;
  logic [CW-1:0]            cls_q, cls_d;

  logic signed [15:0]       va, wa, prod;
  logic signed [ACC_W-1:0]  prod_x, base, sum, r;
  logic signed [7:0]        sat;
  logic                     better;

  always_comb begin
    va     = {{8{v_q[k_q][7]}}, v_q[k_q]};
    wa     = {{8{weight_in[c_q][k_q][7]}}, weight_in[c_q][k_q]};
    prod   = va * wa;
    prod_x = {{(ACC_W-16){prod[15]}}, prod};
    base   = (k_q == '0) ?
             {{(ACC_W-16){bias_in[c_q][15]}}, bias_in[c_q]} : acc_q;
    sum    = acc_q + RND;
    r      = sum >>> SHIFT;
    if (r > P127)      sat = 8'sd127;
    else if (r < N128) sat = -8'sd128;
    else               sat = r[7:0];
    // strict compare: ties keep the lower class index
    better = (c_q == '0) || (r > best_r_q);
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    c_d        = c_q;
    acc_d      = acc_q;
    v_d        = v_q;
    lbuf_d     = lbuf_q;
    logits_d   = logits_q;
    best_r_d   = best_r_q;
    best_idx_d = best_idx_q;
    cls_d      = cls_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          v_d     = vec_in;
          c_d     = '0;
          k_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = base + prod_x;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = STORE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      STORE: begin
        lbuf_d[c_q] = sat;
        if (better) begin
          best_r_d   = r;
          best_idx_d = c_q;
        end
        if (c_q == C_LAST) begin
          logits_d = lbuf_d;
          cls_d    = best_idx_d;
          state_d  = DONE;
        end else begin
          c_d     = c_q + CW'(1);
          state_d = MAC;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      c_q        <= '0;
      acc_q      <= '0;
      v_q        <= '{default: '0};
      lbuf_q     <= '{default: '0};
      logits_q   <= '{default: '0};
      best_r_q   <= '0;
      best_idx_q <= '0;
      cls_q      <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      c_q        <= c_d;
      acc_q      <= acc_d;
      v_q        <= v_d;
      lbuf_q     <= lbuf_d;
      logits_q   <= logits_d;
      best_r_q   <= best_r_d;
      best_idx_q <= best_idx_d;
      cls_q      <= cls_d;
    end
  end

  assign logits_out = logits_q;
  assign class_idx  = cls_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
endmodule

// File: tb/tb_classifier_head.sv
// Directed self-checking bench for classifier_head.
// Expected logits follow CLASSIFIER_HEAD_ROUND_EN when it is defined.
module tb_classifier_head;
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic signed [7:0]  vec   [16];
  logic signed [7:0]  w     [5][16];
  logic signed [15:0] bias  [5];
  logic signed [7:0]  logits [5];
  logic [2:0] cidx;
  logic busy, done;
  int errs = 0;
  int checks = 0;

  classifier_head dut (
    .clk(clk), .rst(rst), .start(start),
    .vec_in(vec), .weight_in(w), .bias_in(bias),
    .logits_out(logits), .class_idx(cidx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic set_vec(input int val);
    for (int k = 0; k < 16; k++) vec[k] = 8'(val);
  endtask

  task automatic set_ramp_w();
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < 16; k++) w[c][k] = 8'(c + 1);
      bias[c] = '0;
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int bcnt);
    cyc = -1;
    bcnt = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    set_vec(0);
    set_ramp_w();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL reset_flags busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    if (cidx !== 3'd0) begin
      errs++;
      $display("FAIL reset_cidx got %0d want 0", cidx);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (logits[i] !== 8'sd0) begin
        errs++;
        $display("FAIL reset_logit[%0d] got %0d want 0", i, logits[i]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_ramp();
    int cyc, bcnt;
    logic signed [7:0] exp [5];
    exp = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5};
    set_vec(1);
    set_ramp_w();
    do_start();
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 86) begin
      errs++;
      $display("FAIL ramp_latency got %0d want 86", cyc);
    end
    checks++;
    if (bcnt !== 86) begin
      errs++;
      $display("FAIL ramp_busy_cycles got %0d want 86", bcnt);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (logits[i] !== exp[i]) begin
        errs++;
        $display("FAIL ramp_logit[%0d] got %0d want %0d", i, logits[i], exp[i]);
      end
    end
    checks++;
    if (cidx !== 3'd4) begin
      errs++;
      $display("FAIL ramp_cidx got %0d want 4", cidx);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL ramp_after done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_saturation();
    int cyc, bcnt;
    logic signed [7:0] exp [5];
    exp = '{8'sd127, -8'sd128, -8'sd128, -8'sd128, -8'sd128};
    set_vec(127);
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < 16; k++) w[c][k] = (c == 0) ? 8'sd127 : -8'sd127;
      bias[c] = '0;
    end
    do_start();
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 86) begin
      errs++;
      $display("FAIL sat_latency got %0d want 86", cyc);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (logits[i] !== exp[i]) begin
        errs++;
        $display("FAIL sat_logit[%0d] got %0d want %0d", i, logits[i], exp[i]);
      end
    end
    checks++;
    if (cidx !== 3'd0) begin
      errs++;
      $display("FAIL sat_cidx got %0d want 0", cidx);
    end
  endtask

  task automatic test_bias_round();
    int cyc, bcnt;
    logic signed [7:0] exp [5];
`ifdef CLASSIFIER_HEAD_ROUND_EN
    exp = '{-8'sd2, 8'sd1, 8'sd3, 8'sd0, 8'sd0};
`else
    exp = '{-8'sd2, 8'sd1, 8'sd3, 8'sd0, -8'sd1};
`endif
    set_vec(0);
    set_ramp_w();
    bias = '{-16'sd32, 16'sd16, 16'sd48, 16'sd0, -16'sd1};
    do_start();
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 86) begin
      errs++;
      $display("FAIL bias_latency got %0d want 86", cyc);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (logits[i] !== exp[i]) begin
        errs++;
        $display("FAIL bias_logit[%0d] got %0d want %0d", i, logits[i], exp[i]);
      end
    end
    checks++;
    if (cidx !== 3'd2) begin
      errs++;
      $display("FAIL bias_cidx got %0d want 2", cidx);
    end
  endtask

  task automatic test_tie();
    int cyc, bcnt;
    set_vec(3);
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < 16; k++) w[c][k] = 8'sd5;
      bias[c] = '0;
    end
    do_start();
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 86) begin
      errs++;
      $display("FAIL tie_latency got %0d want 86", cyc);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (logits[i] !== 8'sd15) begin
        errs++;
        $display("FAIL tie_logit[%0d] got %0d want 15", i, logits[i]);
      end
    end
    checks++;
    if (cidx !== 3'd0) begin
      errs++;
      $display("FAIL tie_cidx got %0d want 0", cidx);
    end
  endtask

  task automatic test_vector_hold();
    int cyc, bcnt;
    logic signed [7:0] exp [5];
    exp = '{8'sd2, 8'sd4, 8'sd6, 8'sd8, 8'sd10};
    set_vec(2);
    set_ramp_w();
    do_start();
    set_vec(-1);
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 86) begin
      errs++;
      $display("FAIL hold_latency got %0d want 86", cyc);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (logits[i] !== exp[i]) begin
        errs++;
        $display("FAIL hold_logit[%0d] got %0d want %0d", i, logits[i], exp[i]);
      end
    end
    checks++;
    if (cidx !== 3'd4) begin
      errs++;
      $display("FAIL hold_cidx got %0d want 4", cidx);
    end
  endtask

  task automatic test_protocol();
    int ndone, first, cyc, bcnt;
    logic signed [7:0] exp [5];
    exp = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5};
    set_vec(1);
    set_ramp_w();
    ndone = 0;
    first = -1;
    do_start();
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first < 0) first = n;
      end
      if (n == 10 || n == 86) start = 1'b1;
      if (n == 11 || n == 87) start = 1'b0;
    end
    checks++;
    if (ndone !== 1) begin
      errs++;
      $display("FAIL proto_done_count got %0d want 1", ndone);
    end
    checks++;
    if (first !== 86) begin
      errs++;
      $display("FAIL proto_done_at got %0d want 86", first);
    end
    do_start();
    for (int n = 1; n <= 30; n++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    ndone = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL abort_state done_count=%0d busy=%b want 0 0", ndone, busy);
    end
    checks++;
    if (cidx !== 3'd0) begin
      errs++;
      $display("FAIL abort_cidx got %0d want 0", cidx);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (logits[i] !== 8'sd0) begin
        errs++;
        $display("FAIL abort_logit[%0d] got %0d want 0", i, logits[i]);
      end
    end
    do_start();
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 86) begin
      errs++;
      $display("FAIL rerun_latency got %0d want 86", cyc);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (logits[i] !== exp[i]) begin
        errs++;
        $display("FAIL rerun_logit[%0d] got %0d want %0d", i, logits[i], exp[i]);
      end
    end
    checks++;
    if (cidx !== 3'd4) begin
      errs++;
      $display("FAIL rerun_cidx got %0d want 4", cidx);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_saturation();
    test_bias_round();
    test_tie();
    test_vector_hold();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
